// File: rtl/uart_rx.sv
// uart_rx: standalone UART receiver with a valid/ready output stream.
// Optional build macro: UART_RX_MAJORITY_EN selects a 2-of-3 majority vote
// around each mid-bit. When it is undefined, one sample is taken at mid-bit.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_en,
  input  logic                  rx_en,
  input  logic                  n_parity_bits,
  input  logic                  n_stop_bits,
  input  logic [DIV_WIDTH-1:0]  internal_clk_divider,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] out_dat_o,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_err_o
);

  localparam int unsigned TICK_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  // Tick-counter value on which a bit decision is taken.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TICK_W-1:0] START_DEC = TICK_W'(OVERSAMPLE / 2);
`else
  localparam logic [TICK_W-1:0] START_DEC = TICK_W'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [TICK_W-1:0]    BIT_DEC   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                  r_rx_meta;
  logic                  r_rx_sync;
  logic                  r_rx_prev;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_stop_ok;
  logic                  r_done;
  logic                  r_done_ferr;
  logic                  r_done_perr;

  logic                  w_en;
  logic                  w_tick;
  logic                  w_start_edge;
  logic [TICK_W-1:0]     w_dec_cnt;
  logic                  w_dec;
  logic                  w_bit;
  logic                  w_last_stop;
  logic                  w_frame_end;

  assign w_en         = uart_en & rx_en;
  assign w_tick       = (r_div_cnt == internal_clk_divider);
  assign w_start_edge = (r_state == ST_IDLE) & w_en & r_rx_prev & ~r_rx_sync;
  assign w_dec_cnt    = (r_state == ST_START) ? START_DEC : BIT_DEC;
  assign w_dec        = w_en & w_tick & (r_state != ST_IDLE) & (r_tick_cnt == w_dec_cnt);
  assign w_last_stop  = ~n_stop_bits | (r_bit_cnt == BIT_CNT_W'(1));

`ifdef UART_RX_MAJORITY_EN
  logic r_maj0;
  logic r_maj1;

  // Capture the two samples that precede the decision tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_maj0 <= 1'b1;
      r_maj1 <= 1'b1;
    end else if (w_tick && (r_state != ST_IDLE)) begin
      if (r_tick_cnt == w_dec_cnt - TICK_W'(2)) r_maj0 <= r_rx_sync;
      if (r_tick_cnt == w_dec_cnt - TICK_W'(1)) r_maj1 <= r_rx_sync;
    end
  end

  assign w_bit = (r_maj0 & r_maj1) | (r_maj0 & r_rx_sync) | (r_maj1 & r_rx_sync);
`else
  assign w_bit = r_rx_sync;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Clock divider: one tick every internal_clk_divider+1 cycles, realigned on a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_start_edge || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

  // Tick counter: position within the current bit, restarted after every decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if ((r_state == ST_IDLE) || w_start_edge) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= w_dec ? '0 : r_tick_cnt + TICK_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and end-of-frame strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    if (!w_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) w_state_nxt = ST_START;
        end
        ST_START: begin
          if (w_dec) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_dec && (r_bit_cnt == LAST_DATA)) begin
            w_state_nxt = n_parity_bits ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_dec) w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          if (w_dec && w_last_stop) begin
            w_state_nxt = ST_IDLE;
            w_frame_end = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Frame datapath: shift data LSB first, capture parity and stop bits, flag completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_stop_ok   <= 1'b1;
      r_done      <= 1'b0;
      r_done_ferr <= 1'b0;
      r_done_perr <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_frame_end) begin
        r_done_ferr <= ~(r_stop_ok & w_bit);
        r_done_perr <= n_parity_bits & (r_par_bit ^ (^r_shift));
      end
      if (w_dec) begin
        case (r_state)
          ST_START: begin
            r_bit_cnt <= '0;
            r_par_bit <= 1'b0;
            r_stop_ok <= 1'b1;
          end
          ST_DATA: begin
            r_shift   <= DATA_WIDTH'({w_bit, r_shift} >> 1);
            r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + BIT_CNT_W'(1);
          end
          ST_PARITY: begin
            r_par_bit <= w_bit;
          end
          ST_STOP: begin
            r_stop_ok <= r_stop_ok & w_bit;
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Output stage: handshake, word load, and error pulses (frame error beats parity error).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dat_o     <= '0;
      out_vld_o     <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
      if (!uart_en) begin
        out_vld_o <= 1'b0;
      end else begin
        if (out_vld_o && out_rdy_i) out_vld_o <= 1'b0;
        if (r_done) begin
          if (r_done_ferr) begin
            frame_err_o <= 1'b1;
          end else if (r_done_perr) begin
            parity_err_o <= 1'b1;
          end else if (!out_vld_o || out_rdy_i) begin
            out_dat_o <= r_shift;
            out_vld_o <= 1'b1;
          end else begin
            overrun_err_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (default build, OVERSAMPLE=16).
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_en;
  logic        rx_en;
  logic        n_parity_bits;
  logic        n_stop_bits;
  logic [15:0] internal_clk_divider;
  logic        rx_i;
  logic [7:0]  out_dat_o;
  logic        out_vld_o;
  logic        out_rdy_i;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_err_o;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0;
  int start_cyc = 0;
  int rise_cnt = 0, rise_cyc = 0, hi_cnt = 0, pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] rise_dat = 8'h00;
  logic prev_vld = 1'b0;
  int b_rise, b_hi, b_pe, b_fe, b_ov;

  uart_rx dut (
    .clk                  (clk),
    .rst                  (rst),
    .uart_en              (uart_en),
    .rx_en                (rx_en),
    .n_parity_bits        (n_parity_bits),
    .n_stop_bits          (n_stop_bits),
    .internal_clk_divider (internal_clk_divider),
    .rx_i                 (rx_i),
    .out_dat_o            (out_dat_o),
    .out_vld_o            (out_vld_o),
    .out_rdy_i            (out_rdy_i),
    .parity_err_o         (parity_err_o),
    .frame_err_o          (frame_err_o),
    .overrun_err_o        (overrun_err_o)
  );

  always #5 clk = ~clk;

  // Posedge counter used as the time base for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_vld_o && !prev_vld) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
      rise_dat <= out_dat_o;
    end
    if (out_vld_o)     hi_cnt <= hi_cnt + 1;
    if (parity_err_o)  pe_cnt <= pe_cnt + 1;
    if (frame_err_o)   fe_cnt <= fe_cnt + 1;
    if (overrun_err_o) ov_cnt <= ov_cnt + 1;
    prev_vld <= out_vld_o;
  end

  task automatic snap();
    b_rise = rise_cnt; b_hi = hi_cnt; b_pe = pe_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame on rx_i; act 1 drops rx_en and act 2 asserts rst after act_at cycles.
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_val,
                            input logic two_stop, input logic stop_val, input int div,
                            input int act_at, input int act);
    logic [11:0] bits;
    int nb;
    int per;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (par_en) begin bits[nb] = par_val; nb++; end
    bits[nb] = stop_val; nb++;
    if (two_stop) begin bits[nb] = stop_val; nb++; end
    per = 16 * (div + 1);
    n = 0;
    @(negedge clk);
    start_cyc = cyc;
    for (int b = 0; b < nb; b++) begin
      rx_i = bits[b];
      for (int k = 0; k < per; k++) begin
        if (n == act_at) begin
          if (act == 1) rx_en = 1'b0;
          else if (act == 2) begin rst = 1'b1; rx_i = 1'b1; return; end
        end
        n++;
        @(negedge clk);
      end
    end
    rx_i = 1'b1;
  endtask

  task automatic test_reset();
    idle(3);
    n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", out_vld_o); end
    n_vec++; if (out_dat_o !== 8'h00) begin n_err++; $display("FAIL reset_dat: got %h want 00", out_dat_o); end
    n_vec++; if ({parity_err_o, frame_err_o, overrun_err_o} !== 3'b000) begin n_err++;
      $display("FAIL reset_err: got %b want 000", {parity_err_o, frame_err_o, overrun_err_o}); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_basic();
    internal_clk_divider = 16'd0; n_parity_bits = 1'b0; n_stop_bits = 1'b0; out_rdy_i = 1'b1;
    snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    n_vec++; if (rise_cnt - b_rise !== 1) begin n_err++; $display("FAIL basic_words: got %0d want 1", rise_cnt - b_rise); end
    n_vec++; if (rise_dat !== 8'hA5) begin n_err++; $display("FAIL basic_dat: got %h want a5", rise_dat); end
    n_vec++; if (rise_cyc - start_cyc !== 156) begin n_err++; $display("FAIL basic_latency: got %0d want 156", rise_cyc - start_cyc); end
    n_vec++; if (hi_cnt - b_hi !== 1) begin n_err++; $display("FAIL basic_vld_width: got %0d want 1", hi_cnt - b_hi); end
    n_vec++; if ((pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov) !== 0) begin n_err++;
      $display("FAIL basic_errs: got %0d/%0d/%0d want 0/0/0", pe_cnt - b_pe, fe_cnt - b_fe, ov_cnt - b_ov); end
  endtask

  task automatic test_parity();
    n_parity_bits = 1'b1; out_rdy_i = 1'b1;
    snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    n_vec++; if (rise_cnt - b_rise !== 1) begin n_err++; $display("FAIL par_good_words: got %0d want 1", rise_cnt - b_rise); end
    n_vec++; if (rise_dat !== 8'h3C) begin n_err++; $display("FAIL par_good_dat: got %h want 3c", rise_dat); end
    n_vec++; if (rise_cyc - start_cyc !== 172) begin n_err++; $display("FAIL par_latency: got %0d want 172", rise_cyc - start_cyc); end
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    n_vec++; if (pe_cnt - b_pe !== 1) begin n_err++; $display("FAIL par_bad_pulse: got %0d want 1", pe_cnt - b_pe); end
    n_vec++; if (rise_cnt - b_rise !== 0) begin n_err++; $display("FAIL par_bad_words: got %0d want 0", rise_cnt - b_rise); end
  endtask

  task automatic test_framing();
    n_parity_bits = 1'b1; out_rdy_i = 1'b1;
    snap();
    // Wrong parity and a low stop bit together: only the frame error reports.
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 0);
    idle(40);
    n_vec++; if (fe_cnt - b_fe !== 1) begin n_err++; $display("FAIL frame_pulse: got %0d want 1", fe_cnt - b_fe); end
    n_vec++; if (pe_cnt - b_pe !== 0) begin n_err++; $display("FAIL frame_prio: got %0d parity pulses want 0", pe_cnt - b_pe); end
    n_vec++; if (rise_cnt - b_rise !== 0) begin n_err++; $display("FAIL frame_words: got %0d want 0", rise_cnt - b_rise); end
    n_parity_bits = 1'b0;
    snap();
    @(negedge clk); rx_i = 1'b0;
    idle(4);
    rx_i = 1'b1;
    idle(60);
    n_vec++; if ((rise_cnt - b_rise) + (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov) !== 0) begin n_err++;
      $display("FAIL glitch_events: got %0d want 0", (rise_cnt - b_rise) + (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov)); end
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    n_vec++; if (rise_dat !== 8'h81) begin n_err++; $display("FAIL glitch_recover_dat: got %h want 81", rise_dat); end
  endtask

  task automatic test_back_to_back_overrun();
    n_parity_bits = 1'b0; out_rdy_i = 1'b0;
    snap();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    n_vec++; if (out_vld_o !== 1'b1) begin n_err++; $display("FAIL ovr_vld: got %b want 1", out_vld_o); end
    n_vec++; if (out_dat_o !== 8'h11) begin n_err++; $display("FAIL ovr_dat: got %h want 11", out_dat_o); end
    n_vec++; if (ov_cnt - b_ov !== 1) begin n_err++; $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - b_ov); end
    out_rdy_i = 1'b1;
    @(negedge clk);
    n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b want 0", out_vld_o); end
  endtask

  task automatic test_divider();
    internal_clk_divider = 16'd3; n_stop_bits = 1'b1; n_parity_bits = 1'b0; out_rdy_i = 1'b1;
    snap();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 3, -1, 0);
    idle(100);
    n_vec++; if (rise_dat !== 8'hF0) begin n_err++; $display("FAIL div_dat: got %h want f0", rise_dat); end
    n_vec++; if (rise_cyc - start_cyc !== 676) begin n_err++; $display("FAIL div_latency: got %0d want 676", rise_cyc - start_cyc); end
    n_vec++; if ((pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov) !== 0) begin n_err++;
      $display("FAIL div_errs: got %0d want 0", (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov)); end
    internal_clk_divider = 16'd0; n_stop_bits = 1'b0;
    idle(10);
  endtask

  task automatic test_rx_en_abort();
    out_rdy_i = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    snap();
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 0, 60, 1);
    idle(20);
    rx_en = 1'b1;
    idle(40);
    n_vec++; if (out_vld_o !== 1'b1) begin n_err++; $display("FAIL rxen_vld_kept: got %b want 1", out_vld_o); end
    n_vec++; if (out_dat_o !== 8'h5A) begin n_err++; $display("FAIL rxen_dat_kept: got %h want 5a", out_dat_o); end
    n_vec++; if ((rise_cnt - b_rise) + (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov) !== 0) begin n_err++;
      $display("FAIL rxen_events: got %0d want 0", (rise_cnt - b_rise) + (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov)); end
    uart_en = 1'b0;
    @(negedge clk);
    n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL uarten_clear: got %b want 0", out_vld_o); end
    uart_en = 1'b1;
    idle(10);
  endtask

  task automatic test_reset_midframe();
    out_rdy_i = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    n_vec++; if (out_vld_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pending: got %b want 1", out_vld_o); end
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 0, 50, 2);
    #1;
    n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL rstmid_vld: got %b want 0", out_vld_o); end
    n_vec++; if (out_dat_o !== 8'h00) begin n_err++; $display("FAIL rstmid_dat: got %h want 00", out_dat_o); end
    @(negedge clk);
    rst = 1'b0; out_rdy_i = 1'b1;
    idle(20);
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1, 0);
    idle(40);
    n_vec++; if (rise_dat !== 8'h3C) begin n_err++; $display("FAIL rstmid_next_dat: got %h want 3c", rise_dat); end
    n_vec++; if (rise_cyc - start_cyc !== 156) begin n_err++; $display("FAIL rstmid_next_lat: got %0d want 156", rise_cyc - start_cyc); end
    n_vec++; if ((pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov) !== 0) begin n_err++;
      $display("FAIL rstmid_errs: got %0d want 0", (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov)); end
  endtask

  initial begin
    rst = 1'b1; uart_en = 1'b1; rx_en = 1'b1; n_parity_bits = 1'b0; n_stop_bits = 1'b0;
    internal_clk_divider = 16'd0; rx_i = 1'b1; out_rdy_i = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back_overrun();
    test_divider();
    test_rx_en_abort();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
